// File: rtl/ma_pma_pkg.sv
// Shared types and constants for the runtime-programmable PMA region unit.
package ma_pma_pkg;

    // Attribute word layout, LSB first: valid, exec, cached, nonidem, lock.
    typedef struct packed {
        logic lock;
        logic nonidem;
        logic cached;
        logic exec;
        logic valid;
    } pma_attr_t;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] len;
        pma_attr_t   attr;
    } pma_region_t;

    // Word offset inside a region's four-word register block.
    typedef enum logic [1:0] {
        WORD_BASE = 2'd0,
        WORD_LEN  = 2'd1,
        WORD_ATTR = 2'd2,
        WORD_RSVD = 2'd3
    } pma_word_e;

    localparam int unsigned AttrWidth = $bits(pma_attr_t);

endpackage

// File: rtl/ma_pma_match.sv
// Combinational address-in-region comparator for one PMA region.
module ma_pma_match #(
    parameter int unsigned AddrWidth = 32
) (
    input  logic [AddrWidth-1:0] i_addr,
    input  logic [AddrWidth-1:0] i_base,
    input  logic [AddrWidth-1:0] i_len,
    input  logic                 i_valid,
    output logic                 o_match
);

    logic [AddrWidth-1:0] w_off;

    // Offset is only meaningful once addr >= base, so it never wraps.
    assign w_off   = i_addr - i_base;
    assign o_match = i_valid && (i_len != '0) && (i_addr >= i_base) && (w_off < i_len);

endmodule

// File: rtl/ma_pma_region_unit.sv
// PMA region table with req/gnt register port and one-cycle registered lookup.
module ma_pma_region_unit
    import ma_pma_pkg::*;
#(
    parameter int unsigned NrRegions = 8,
    parameter int unsigned AddrWidth = 32,
    parameter logic [31:0] Rst0Base  = 32'h8000_0000,
    parameter logic [31:0] Rst0Len   = 32'h0001_0000,
    parameter logic [4:0]  Rst0Attr  = 5'b00111,
    localparam int unsigned CfgAw    = $clog2(NrRegions*4+1),
    localparam int unsigned IdxW     = (NrRegions > 1) ? $clog2(NrRegions) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_req_i,
    input  logic                 cfg_we_i,
    input  logic [CfgAw-1:0]     cfg_addr_i,
    input  logic [31:0]          cfg_wdata_i,
    output logic                 cfg_gnt_o,
    output logic                 cfg_rvalid_o,
    output logic [31:0]          cfg_rdata_o,
    output logic                 cfg_err_o,
    input  logic                 lookup_valid_i,
    input  logic [AddrWidth-1:0] lookup_addr_i,
    output logic                 lookup_valid_o,
    output logic                 lookup_hit_o,
    output logic [IdxW-1:0]      lookup_idx_o,
    output logic                 lookup_exec_o,
    output logic                 lookup_cached_o,
    output logic                 lookup_nonidem_o
);

    localparam logic [CfgAw-1:0] MissAddr = CfgAw'(NrRegions*4);

    pma_region_t          r_regions [NrRegions];
    logic [31:0]          r_misscnt;
    logic                 r_cfg_rvalid;
    logic [31:0]          r_cfg_rdata;
    logic                 r_cfg_err;
    logic                 r_lk_valid;
    logic                 r_lk_hit;
    logic [IdxW-1:0]      r_lk_idx;
    logic                 r_lk_exec;
    logic                 r_lk_cached;
    logic                 r_lk_nonidem;

    logic [NrRegions-1:0] w_match;
    logic                 w_hit;
    logic [IdxW-1:0]      w_idx;
    pma_attr_t            w_sel_attr;
    logic                 w_in_region;
    logic                 w_is_miss;
    logic [IdxW-1:0]      w_reg_idx;
    pma_word_e            w_word;
    logic                 w_wr_en;
    logic [31:0]          w_rdata;
    logic                 w_err;

    for (genvar g = 0; g < NrRegions; g++) begin : g_match
        ma_pma_match #(
            .AddrWidth(AddrWidth)
        ) u_match (
            .i_addr (lookup_addr_i),
            .i_base (r_regions[g].base[AddrWidth-1:0]),
            .i_len  (r_regions[g].len[AddrWidth-1:0]),
            .i_valid(r_regions[g].attr.valid),
            .o_match(w_match[g])
        );
    end

    // Priority select: lowest matching region index wins.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int unsigned i = 0; i < NrRegions; i++) begin
            if (w_match[i] && !w_hit) begin
                w_hit = 1'b1;
                w_idx = IdxW'(i);
            end
        end
    end

    assign w_sel_attr  = r_regions[w_idx].attr;
    assign w_in_region = cfg_addr_i < MissAddr;
    assign w_is_miss   = cfg_addr_i == MissAddr;
    assign w_reg_idx   = cfg_addr_i[IdxW+1:2];
    assign w_word      = pma_word_e'(cfg_addr_i[1:0]);

    // Register-port decode: read data, error and write enable for this request.
    always_comb begin
        w_rdata = '0;
        w_err   = 1'b0;
        w_wr_en = 1'b0;
        if (cfg_req_i) begin
            if (w_in_region) begin
                if (cfg_we_i) begin
                    if (r_regions[w_reg_idx].attr.lock) w_err = 1'b1;
                    else                               w_wr_en = 1'b1;
                end else begin
                    case (w_word)
                        WORD_BASE: w_rdata = r_regions[w_reg_idx].base;
                        WORD_LEN:  w_rdata = r_regions[w_reg_idx].len;
                        WORD_ATTR: w_rdata = {{(32-AttrWidth){1'b0}}, r_regions[w_reg_idx].attr};
                        default:   w_rdata = '0;
                    endcase
                end
            end else if (w_is_miss) begin
                if (cfg_we_i) w_err   = 1'b1;
                else          w_rdata = r_misscnt;
            end else begin
                w_err = 1'b1;
            end
        end
    end

    assign cfg_gnt_o = cfg_req_i;

    // Region table updates and registered config response.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NrRegions; i++) begin
                r_regions[i] <= '0;
            end
            r_regions[0].base <= Rst0Base;
            r_regions[0].len  <= Rst0Len;
            r_regions[0].attr <= pma_attr_t'(Rst0Attr);
            r_cfg_rvalid      <= 1'b0;
            r_cfg_rdata       <= '0;
            r_cfg_err         <= 1'b0;
        end else begin
            r_cfg_rvalid <= cfg_req_i;
            r_cfg_rdata  <= w_rdata;
            r_cfg_err    <= w_err;
            if (w_wr_en) begin
                case (w_word)
                    WORD_BASE: r_regions[w_reg_idx].base <= cfg_wdata_i;
                    WORD_LEN:  r_regions[w_reg_idx].len  <= cfg_wdata_i;
                    WORD_ATTR: r_regions[w_reg_idx].attr <= pma_attr_t'(cfg_wdata_i[AttrWidth-1:0]);
                    default:   ;
                endcase
            end
        end
    end

    // Registered lookup result (zeroed unless valid) and saturating miss counter.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_lk_valid   <= 1'b0;
            r_lk_hit     <= 1'b0;
            r_lk_idx     <= '0;
            r_lk_exec    <= 1'b0;
            r_lk_cached  <= 1'b0;
            r_lk_nonidem <= 1'b0;
            r_misscnt    <= '0;
        end else begin
            r_lk_valid   <= lookup_valid_i;
            r_lk_hit     <= lookup_valid_i && w_hit;
            r_lk_idx     <= (lookup_valid_i && w_hit) ? w_idx : '0;
            r_lk_exec    <= lookup_valid_i && w_hit && w_sel_attr.exec;
            r_lk_cached  <= lookup_valid_i && w_hit && w_sel_attr.cached;
            r_lk_nonidem <= lookup_valid_i && w_hit && w_sel_attr.nonidem;
            if (lookup_valid_i && !w_hit && (r_misscnt != '1)) begin
                r_misscnt <= r_misscnt + 32'd1;
            end
        end
    end

    assign cfg_rvalid_o     = r_cfg_rvalid;
    assign cfg_rdata_o      = r_cfg_rdata;
    assign cfg_err_o        = r_cfg_err;
    assign lookup_valid_o   = r_lk_valid;
    assign lookup_hit_o     = r_lk_hit;
    assign lookup_idx_o     = r_lk_idx;
    assign lookup_exec_o    = r_lk_exec;
    assign lookup_cached_o  = r_lk_cached;
    assign lookup_nonidem_o = r_lk_nonidem;

endmodule
